// File: rtl/jtcontra_vbank.sv
// Graphics ROM bank controller: per-channel shadow/active bank registers, tile-address
// banking with object bypass, and a guard that hides stale rom_ok after address changes.

module jtcontra_vbank_ch #(
   parameter int LW    = 14,
   parameter int BW    = 4,
   parameter int MODE  = 1,
   parameter int GUARD = 2,
   localparam int AW   = LW + BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic          vb_edge,
   input  logic [BW-1:0] din,
   input  logic          obj_sel,
   input  logic [AW-1:0] pre_addr,
   input  logic          pre_cs,
   input  logic          rom_ok,
   output logic [BW-1:0] active,
   output logic          pend,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   output logic          data_ok
);
   localparam logic [2:0] GLOAD = 3'(GUARD);

   logic [BW-1:0] shadow, shadow_nxt, active_nxt;
   logic          pend_nxt;
   logic [AW-1:0] addr_nxt;
   logic [2:0]    guard_cnt, guard_nxt;

   always_comb begin
      shadow_nxt = shadow;
      active_nxt = active;
      pend_nxt   = pend;
      if (MODE == 0) begin
         if (pend) begin
            active_nxt = shadow;
            pend_nxt   = 1'b0;
         end
         if (wr) begin
            shadow_nxt = din;
            pend_nxt   = 1'b1;
         end
      end else if (vb_edge && wr) begin
         // a write landing on the blanking edge takes effect immediately
         shadow_nxt = din;
         active_nxt = din;
         pend_nxt   = 1'b0;
      end else begin
         if (vb_edge && pend) begin
            active_nxt = shadow;
            pend_nxt   = 1'b0;
         end
         if (wr) begin
            shadow_nxt = din;
            pend_nxt   = 1'b1;
         end
      end
   end

   // bit LW of a tile address selects banked space; upper chip bits are dropped
   always_comb begin
      addr_nxt = obj_sel ? pre_addr
                         : {active & {BW{pre_addr[LW]}}, pre_addr[LW-1:0]};
   end

   always_comb begin
      guard_nxt = guard_cnt;
      if (addr_nxt != rom_addr || active_nxt != active)
         guard_nxt = GLOAD;
      else if (guard_cnt != 3'd0)
         guard_nxt = guard_cnt - 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow    <= '0;
         active    <= '0;
         pend      <= 1'b0;
         guard_cnt <= 3'd0;
         rom_addr  <= '0;
         rom_cs    <= 1'b0;
      end else begin
         shadow    <= shadow_nxt;
         active    <= active_nxt;
         pend      <= pend_nxt;
         guard_cnt <= guard_nxt;
         rom_addr  <= addr_nxt;
         rom_cs    <= pre_cs;
      end
   end

   assign data_ok = rom_ok & rom_cs & (guard_cnt == 3'd0) & ~rst;
endmodule

module jtcontra_vbank #(
   parameter int CH    = 2,
   parameter int LW    = 14,
   parameter int BW    = 4,
   parameter int MODE  = 1,
   parameter int GUARD = 2,
   localparam int AW   = LW + BW,
   localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pxl_cen,
   input  logic             LVBL,
   input  logic             cpu_cen,
   input  logic             bank_we,
   input  logic [CHW-1:0]   bank_ch,
   input  logic [BW-1:0]    bank_din,
   output logic [BW-1:0]    bank_dout,
   output logic [CH-1:0]    bank_pend,
   input  logic [CH-1:0]    obj_sel,
   input  logic [CH*AW-1:0] pre_addr,
   input  logic [CH-1:0]    pre_cs,
   output logic [CH*AW-1:0] rom_addr,
   output logic [CH-1:0]    rom_cs,
   input  logic [CH-1:0]    rom_ok,
   output logic [CH-1:0]    data_ok
);
   localparam logic [CHW:0] CHL = (CHW+1)'(CH);

   logic                  lvbl_l, vb_edge, ch_ok;
   logic [CH-1:0]         wr_sel;
   logic [CH-1:0][BW-1:0] active;

   always_ff @(posedge clk) begin
      if (rst)          lvbl_l <= 1'b0;
      else if (pxl_cen) lvbl_l <= LVBL;
   end

   assign vb_edge = pxl_cen & lvbl_l & ~LVBL;
   assign ch_ok   = {1'b0, bank_ch} < CHL;

   always_comb begin
      wr_sel = '0;
      if (bank_we && cpu_cen && ch_ok) wr_sel[bank_ch] = 1'b1;
   end

   assign bank_dout = ch_ok ? active[bank_ch] : '0;

   for (genvar n = 0; n < CH; n++) begin : g_ch
      jtcontra_vbank_ch #(
         .LW(LW), .BW(BW), .MODE(MODE), .GUARD(GUARD)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .wr       (wr_sel[n]),
         .vb_edge  (vb_edge),
         .din      (bank_din),
         .obj_sel  (obj_sel[n]),
         .pre_addr (pre_addr[n*AW +: AW]),
         .pre_cs   (pre_cs[n]),
         .rom_ok   (rom_ok[n]),
         .active   (active[n]),
         .pend     (bank_pend[n]),
         .rom_addr (rom_addr[n*AW +: AW]),
         .rom_cs   (rom_cs[n]),
         .data_ok  (data_ok[n])
      );
   end
endmodule

// File: tb/tb_jtcontra_vbank.sv
// Bench for jtcontra_vbank: a MODE=0 and a MODE=1 instance share stimulus; a scoreboard
// of reference-model predictions is checked by a monitor, plus directed spot checks.

module tb_jtcontra_vbank;
   localparam int CH = 2, LW = 14, BW = 4, GUARD = 2, AW = LW + BW;

   logic             clk = 1'b0;
   logic             rst, pxl_cen, LVBL, cpu_cen, bank_we;
   logic [0:0]       bank_ch;
   logic [BW-1:0]    bank_din;
   logic [CH-1:0]    obj_sel, pre_cs, rom_ok;
   logic [CH*AW-1:0] pre_addr;

   logic [BW-1:0]    dout0, dout1;
   logic [CH-1:0]    pend0, pend1, cs0, cs1, dok0, dok1;
   logic [CH*AW-1:0] addr0, addr1;

   always #5 clk = ~clk;

   jtcontra_vbank #(.CH(CH), .LW(LW), .BW(BW), .MODE(0), .GUARD(GUARD)) u0 (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LVBL(LVBL), .cpu_cen(cpu_cen),
      .bank_we(bank_we), .bank_ch(bank_ch), .bank_din(bank_din), .bank_dout(dout0),
      .bank_pend(pend0), .obj_sel(obj_sel), .pre_addr(pre_addr), .pre_cs(pre_cs),
      .rom_addr(addr0), .rom_cs(cs0), .rom_ok(rom_ok), .data_ok(dok0));

   jtcontra_vbank #(.CH(CH), .LW(LW), .BW(BW), .MODE(1), .GUARD(GUARD)) u1 (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LVBL(LVBL), .cpu_cen(cpu_cen),
      .bank_we(bank_we), .bank_ch(bank_ch), .bank_din(bank_din), .bank_dout(dout1),
      .bank_pend(pend1), .obj_sel(obj_sel), .pre_addr(pre_addr), .pre_cs(pre_cs),
      .rom_addr(addr1), .rom_cs(cs1), .rom_ok(rom_ok), .data_ok(dok1));

   typedef struct packed {
      logic [1:0][CH*AW-1:0] addr;
      logic [1:0][CH-1:0]    cs, pend, dok;
      logic [1:0][BW-1:0]    dout;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0, n_bad = 0;

   // reference state, index [mode][channel]
   int         r_sh[2][CH], r_ac[2][CH], r_pd[2][CH], r_gd[2][CH];
   logic [AW-1:0] r_ad[2][CH];
   logic [CH-1:0] r_cs[2];
   logic          r_lv[2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      exp_t          e;
      int            ac, sh, pd;
      bit            wr, vb;
      logic [AW-1:0] p, na;
      e = '0;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            for (int n = 0; n < CH; n++) begin
               r_sh[m][n] = 0; r_ac[m][n] = 0; r_pd[m][n] = 0; r_gd[m][n] = 0; r_ad[m][n] = '0;
            end
            r_cs[m] = '0;
            r_lv[m] = 1'b0;
         end else begin
            wr = bank_we && cpu_cen;
            vb = pxl_cen && r_lv[m] && !LVBL;
            for (int n = 0; n < CH; n++) begin
               p  = pre_addr[n*AW +: AW];
               na = obj_sel[n] ? p
                  : AW'((p[LW] ? r_ac[m][n] * (1 << LW) : 0) + int'(p) % (1 << LW));
               ac = r_ac[m][n]; sh = r_sh[m][n]; pd = r_pd[m][n];
               if (m == 0) begin
                  if (pd != 0) begin ac = sh; pd = 0; end
                  if (wr && bank_ch == n) begin sh = int'(bank_din); pd = 1; end
               end else if (vb && wr && bank_ch == n) begin
                  sh = int'(bank_din); ac = sh; pd = 0;
               end else begin
                  if (vb && pd != 0) begin ac = sh; pd = 0; end
                  if (wr && bank_ch == n) begin sh = int'(bank_din); pd = 1; end
               end
               if (na != r_ad[m][n] || ac != r_ac[m][n]) r_gd[m][n] = GUARD;
               else if (r_gd[m][n] > 0)                  r_gd[m][n] = r_gd[m][n] - 1;
               r_ad[m][n] = na; r_ac[m][n] = ac; r_sh[m][n] = sh; r_pd[m][n] = pd;
            end
            r_cs[m] = pre_cs;
            if (pxl_cen) r_lv[m] = LVBL;
         end
         for (int n = 0; n < CH; n++) begin
            e.addr[m][n*AW +: AW] = r_ad[m][n];
            e.cs[m][n]   = r_cs[m][n];
            e.pend[m][n] = (r_pd[m][n] != 0);
            e.dok[m][n]  = rom_ok[n] && r_cs[m][n] && r_gd[m][n] == 0 && !rst;
         end
         e.dout[m] = BW'(r_ac[m][bank_ch]);
      end
      sbq.push_back(e);
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("m0 rom_addr",  64'(addr0), 64'(e.addr[0]));
         chk("m0 rom_cs",    64'(cs0),   64'(e.cs[0]));
         chk("m0 bank_pend", 64'(pend0), 64'(e.pend[0]));
         chk("m0 data_ok",   64'(dok0),  64'(e.dok[0]));
         chk("m0 bank_dout", 64'(dout0), 64'(e.dout[0]));
         chk("m1 rom_addr",  64'(addr1), 64'(e.addr[1]));
         chk("m1 rom_cs",    64'(cs1),   64'(e.cs[1]));
         chk("m1 bank_pend", 64'(pend1), 64'(e.pend[1]));
         chk("m1 data_ok",   64'(dok1),  64'(e.dok[1]));
         chk("m1 bank_dout", 64'(dout1), 64'(e.dout[1]));
      end
   end

   initial begin
      logic [AW-1:0] p0, p1;
      rst = 1'b1; pxl_cen = 1'b1; LVBL = 1'b1; cpu_cen = 1'b1; bank_we = 1'b1;
      bank_ch = 1'b0; bank_din = 4'hF; obj_sel = '0; pre_addr = '0; pre_cs = 2'b11;
      rom_ok = '0;
      repeat (3) tick();
      chk("rst rom_cs",    64'(cs1),   64'd0);
      chk("rst bank_pend", 64'(pend1), 64'd0);
      chk("rst rom_addr",  64'(addr1), 64'd0);
      chk("rst data_ok",   64'(dok1),  64'd0);
      rst = 1'b0; bank_we = 1'b0;
      tick();
      chk("first rom_cs", 64'(cs1), 64'd3);

      // tile banking
      bank_we = 1'b1; bank_ch = 1'b1; bank_din = 4'hA;
      tick();
      bank_we = 1'b0; pre_addr[AW +: AW] = 18'h04123;
      tick(); tick();
      chk("pre-vbl addr1", 64'(addr1[AW +: AW]), 64'h00123);
      chk("pre-vbl pend",  64'(pend1), 64'b10);
      chk("mode0 addr1",   64'(addr0[AW +: AW]), 64'h28123);
      LVBL = 1'b0;
      tick(); tick();
      chk("vbl addr1", 64'(addr1[AW +: AW]), 64'h28123);
      chk("vbl pend",  64'(pend1), 64'b00);
      pre_addr[AW +: AW] = 18'h00123;
      tick();
      chk("bit14 low addr1", 64'(addr1[AW +: AW]), 64'h00123);
      LVBL = 1'b1;
      tick();

      // object bypass with active0 = 5
      bank_we = 1'b1; bank_ch = 1'b0; bank_din = 4'h5;
      tick();
      bank_we = 1'b0; LVBL = 1'b0;
      tick();
      LVBL = 1'b1; obj_sel = 2'b01; pre_addr[0 +: AW] = 18'h3ABCD;
      tick();
      chk("obj addr0 m1", 64'(addr1[0 +: AW]), 64'h3ABCD);
      chk("obj addr0 m0", 64'(addr0[0 +: AW]), 64'h3ABCD);
      obj_sel = '0;
      tick();

      // write coinciding with the blanking edge
      LVBL = 1'b0; bank_we = 1'b1; bank_din = 4'h3;
      tick();
      chk("edge+wr dout", 64'(dout1), 64'h3);
      chk("edge+wr pend", 64'(pend1[0]), 64'd0);
      bank_din = 4'h7;
      tick();
      bank_we = 1'b0;
      tick();
      chk("late wr pend", 64'(pend1[0]), 64'd1);
      chk("late wr dout", 64'(dout1), 64'h3);
      LVBL = 1'b1; tick();
      LVBL = 1'b0; tick();
      chk("next vbl dout", 64'(dout1), 64'h7);
      chk("next vbl pend", 64'(pend1[0]), 64'd0);
      LVBL = 1'b1;

      // guard window and restart
      rom_ok = 2'b11; pre_cs = 2'b11; pre_addr[0 +: AW] = 18'h00010;
      repeat (4) tick();
      chk("guard idle", 64'(dok1[0]), 64'd1);
      pre_addr[0 +: AW] = 18'h00020;
      tick(); chk("guard c1", 64'(dok1[0]), 64'd0);
      tick(); chk("guard c2", 64'(dok1[0]), 64'd0);
      tick(); chk("guard open", 64'(dok1[0]), 64'd1);
      pre_addr[0 +: AW] = 18'h00030; tick(); tick();
      pre_addr[0 +: AW] = 18'h00040;
      tick(); chk("reload c1", 64'(dok1[0]), 64'd0);
      tick(); chk("reload c2", 64'(dok1[0]), 64'd0);
      tick(); chk("reload open", 64'(dok1[0]), 64'd1);

      // immediate mode: bank visible two clocks after the write
      pre_addr[0 +: AW] = 18'h04000;
      tick();
      bank_we = 1'b1; bank_din = 4'h9;
      tick();
      bank_we = 1'b0;
      tick(); tick();
      chk("mode0 bank", 64'(addr0[AW-1:LW]), 64'h9);

      // randomized phase
      p0 = pre_addr[0 +: AW]; p1 = pre_addr[AW +: AW];
      for (int i = 0; i < 2500; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         pxl_cen  = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 19) == 0) LVBL = ~LVBL;
         cpu_cen  = $urandom_range(0, 3) != 0;
         bank_we  = $urandom_range(0, 5) == 0;
         bank_ch  = 1'($urandom_range(0, 1));
         bank_din = BW'($urandom);
         obj_sel  = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
         if ($urandom_range(0, 4) == 0) p0 = AW'($urandom);
         if ($urandom_range(0, 4) == 0) p1 = AW'($urandom);
         pre_addr = {p1, p0};
         pre_cs   = CH'($urandom);
         rom_ok   = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
         tick();
      end
      rst = 1'b0; bank_we = 1'b0;
      repeat (3) @(negedge clk);
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard drain: %0d left, want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
